auto_seq_arbiter: RTL and testbench

- Round-robin scheduler that shares one serial Mealy automaton engine (1-bit input x, outputs t1/t2, sync state clear) between N_REQ requesters.
- Each requester submits an LEN-bit word. The block grants one requester, clears the engine to its initial state, and streams the word LSB-first into the engine.
- It captures t1/t2 on every bit into result words, then signals completion.
- Sits between the requester logic and the engine instance.

---
 rtl/auto_seq_arbiter_if.sv | 31 +++
 rtl/auto_seq_arbiter.sv | 124 ++++++++++++
 tb/tb_auto_seq_arbiter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/auto_seq_arbiter_if.sv
// Requester and engine signals of the round-robin serial engine arbiter.
// The arbiter sits on the slave modport; requesters plus engine stub use master.
interface auto_seq_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int LEN   = 8,
    parameter int IW    = $clog2(N_REQ)
);
    logic [N_REQ-1:0]     req;
    logic [N_REQ*LEN-1:0] req_data;
    logic [N_REQ-1:0]     gnt;
    logic                 busy;
    logic                 done;
    logic [IW-1:0]        done_id;
    logic [LEN-1:0]       res_t1;
    logic [LEN-1:0]       res_t2;
    logic                 eng_init;
    logic                 eng_en;
    logic                 eng_x;
    logic                 eng_t1;
    logic                 eng_t2;

    modport master (
        output req, req_data, eng_t1, eng_t2,
        input  gnt, busy, done, done_id, res_t1, res_t2, eng_init, eng_en, eng_x
    );

    modport slave (
        input  req, req_data, eng_t1, eng_t2,
        output gnt, busy, done, done_id, res_t1, res_t2, eng_init, eng_en, eng_x
    );
endinterface

// File: rtl/auto_seq_arbiter.sv
// Round-robin sharing of one serial Mealy engine between N_REQ requesters:
// grant, clear engine, stream the latched word LSB-first, capture t1/t2 per bit.
//
//   state | meaning
//   IDLE  | waiting for any request, round-robin pick from rr_last+1
//   INIT  | one cycle of engine synchronous clear
//   RUN   | LEN cycles streaming sr into the engine, capturing t1/t2
//   DONE  | one-cycle completion pulse, grant released on exit
module auto_seq_arbiter #(
    parameter int N_REQ = 4,
    parameter int LEN   = 8,
    parameter int IW    = $clog2(N_REQ),
    parameter int CW    = $clog2(LEN)
) (
    input  logic               clk,
    input  logic               res,
    auto_seq_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, INIT, RUN, DONE} state_t;

    state_t         state;
    logic [IW-1:0]  cur;
    logic [IW-1:0]  rr_last;
    logic [LEN-1:0] sr;
    logic [CW-1:0]  bit_cnt;

    logic [LEN-1:0] words [N_REQ];
    logic [IW-1:0]  pick;
    logic [IW-1:0]  idx;
    logic           pick_vld;

    for (genvar g = 0; g < N_REQ; g++) begin : g_words
        assign words[g] = bus.req_data[g*LEN +: LEN];
    end

    // Descending scan so the candidate closest after rr_last wins.
    always_comb begin
        pick     = '0;
        idx      = '0;
        pick_vld = 1'b0;
        for (int i = N_REQ; i >= 1; i--) begin
            idx = IW'((int'(rr_last) + i) % N_REQ);
            if (bus.req[idx]) begin
                pick     = idx;
                pick_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state        <= IDLE;
            cur          <= '0;
            rr_last      <= IW'(N_REQ - 1);
            sr           <= '0;
            bit_cnt      <= '0;
            bus.gnt      <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.done_id  <= '0;
            bus.res_t1   <= '0;
            bus.res_t2   <= '0;
            bus.eng_init <= 1'b0;
            bus.eng_en   <= 1'b0;
            bus.eng_x    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (pick_vld) begin
                        cur          <= pick;
                        rr_last      <= pick;
                        sr           <= words[pick];
                        bus.gnt      <= N_REQ'(1) << pick;
                        bus.busy     <= 1'b1;
                        bus.eng_init <= 1'b1;
                        state        <= INIT;
                    end
                end
                INIT, RUN: begin
                    if (!bus.req[cur]) begin
                        // Abort: results stay partially written, rr_last keeps cur.
                        state        <= IDLE;
                        bus.gnt      <= '0;
                        bus.busy     <= 1'b0;
                        bus.eng_init <= 1'b0;
                        bus.eng_en   <= 1'b0;
                        bus.eng_x    <= 1'b0;
                        bit_cnt      <= '0;
                    end else if (state == INIT) begin
                        bus.eng_init <= 1'b0;
                        bus.eng_en   <= 1'b1;
                        bus.eng_x    <= sr[0];
                        sr           <= sr >> 1;
                        bit_cnt      <= '0;
                        state        <= RUN;
                    end else begin
                        bus.res_t1[bit_cnt] <= bus.eng_t1;
                        bus.res_t2[bit_cnt] <= bus.eng_t2;
                        if (bit_cnt == CW'(LEN - 1)) begin
                            bit_cnt     <= '0;
                            bus.eng_en  <= 1'b0;
                            bus.eng_x   <= 1'b0;
                            bus.done    <= 1'b1;
                            bus.done_id <= cur;
                            state       <= DONE;
                        end else begin
                            bit_cnt   <= bit_cnt + 1'b1;
                            bus.eng_x <= sr[0];
                            sr        <= sr >> 1;
                        end
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    bus.gnt  <= '0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_auto_seq_arbiter.sv
// Directed bench for auto_seq_arbiter with a scoreboard of expected completions
// and a small four-state Mealy engine (or a pass-through stub) on the engine port.
module tb_auto_seq_arbiter;
    localparam int N_REQ = 4;
    localparam int LEN   = 8;

    logic clk = 1'b0;
    logic res = 1'b0;
    bit   real_eng = 1'b0;
    logic [1:0] q = 2'd0;
    int   cyc_cnt = 0;
    int   n_total = 0;
    int   n_pass  = 0;

    typedef struct {
        logic [1:0] id;
        logic [7:0] t1;
        logic [7:0] t2;
    } exp_t;
    exp_t sb[$];

    auto_seq_arbiter_if #(.N_REQ(N_REQ), .LEN(LEN)) bus ();

    auto_seq_arbiter #(.N_REQ(N_REQ), .LEN(LEN)) dut (
        .clk (clk),
        .res (res),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Engine: x=0 walks 0,1,2,3; x=1 walks backwards; init clears to 0.
    always @(posedge clk) begin
        if (bus.eng_init)    q <= 2'd0;
        else if (bus.eng_en) q <= bus.eng_x ? q - 2'd1 : q + 2'd1;
    end
    assign bus.eng_t1 = real_eng ? (q[0] ^ bus.eng_x) : bus.eng_x;
    assign bus.eng_t2 = real_eng ? (~(q[1] ^ q[0]) ^ bus.eng_x) : ~bus.eng_x;

    function automatic logic [15:0] eng_model(input logic [7:0] w);
        logic [1:0] m;
        logic [7:0] t1;
        logic [7:0] t2;
        m = 2'd0;
        for (int k = 0; k < 8; k++) begin
            t1[k] = m[0] ^ w[k];
            t2[k] = ~(m[1] ^ m[0]) ^ w[k];
            m     = w[k] ? m - 2'd1 : m + 2'd1;
        end
        return {t2, t1};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push(input int id, input logic [7:0] t1, input logic [7:0] t2);
        exp_t e;
        e.id = 2'(id);
        e.t1 = t1;
        e.t2 = t2;
        sb.push_back(e);
    endtask

    task automatic wait_gnt(output int c);
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (bus.gnt == '0 && c < 40);
        check("gnt_seen", |bus.gnt, 1);
    endtask

    task automatic wait_done(output int c);
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!bus.done && c < 40);
        check("done_seen", bus.done, 1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (res) begin
            check("gnt_onehot0", $onehot0(bus.gnt), 1);
            check("init_en_excl", bus.eng_init & bus.eng_en, 0);
            if (bus.done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", bus.done, 0);
                end else begin
                    e = sb.pop_front();
                    check("done_id", bus.done_id, e.id);
                    check("res_t1", bus.res_t1, e.t1);
                    check("res_t2", bus.res_t2, e.t2);
                end
            end
        end
    end

    initial begin
        int c;
        int prev;
        logic [15:0] m;
        logic [3:0] exp_g;

        bus.req      = '0;
        bus.req_data = '0;
        repeat (3) @(negedge clk);
        check("rst_gnt", bus.gnt, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_res_t1", bus.res_t1, 0);

        // 1: idle after reset release
        res = 1'b1;
        repeat (10) @(negedge clk);
        check("idle_busy", bus.busy, 0);
        check("idle_gnt", bus.gnt, 0);
        check("idle_done", bus.done, 0);
        check("idle_eng", {bus.eng_init, bus.eng_en, bus.eng_x}, 0);

        // 2: single request, stub engine
        bus.req_data[0*8 +: 8] = 8'hA5;
        bus.req = 4'b0001;
        push(0, 8'hA5, 8'h5A);
        wait_gnt(c);
        check("gnt_latency", c, 1);
        check("gnt0", bus.gnt, 4'b0001);
        check("init_pulse", {bus.eng_init, bus.eng_en, bus.busy}, 3'b101);
        wait_done(c);
        check("done_latency", c, 9);
        check("t1_A5", bus.res_t1, 8'hA5);
        bus.req = '0;
        @(negedge clk);
        check("done_pulse_end", {bus.done, bus.gnt, bus.busy}, 0);

        // 3: real automaton engine on requester 3
        real_eng = 1'b1;
        bus.req_data[3*8 +: 8] = 8'h00;
        bus.req = 4'b1000;
        push(3, 8'hAA, 8'h99);
        wait_gnt(c);
        check("gnt3", bus.gnt, 4'b1000);
        wait_done(c);
        check("done_latency_eng", c, 9);
        bus.req = '0;
        @(negedge clk);
        bus.req_data[3*8 +: 8] = 8'h3C;
        m = eng_model(8'h3C);
        push(3, m[7:0], m[15:8]);
        bus.req = 4'b1000;
        wait_gnt(c);
        bus.req_data[3*8 +: 8] = 8'hFF;
        wait_done(c);
        bus.req = '0;
        @(negedge clk);
        real_eng = 1'b0;

        // 4: all requesting, round-robin order and throughput
        bus.req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        push(0, 8'h11, 8'hEE);
        push(1, 8'h22, 8'hDD);
        push(2, 8'h33, 8'hCC);
        push(3, 8'h44, 8'hBB);
        push(0, 8'h11, 8'hEE);
        bus.req = 4'b1111;
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            wait_gnt(c);
            exp_g = 4'(1 << (k % 4));
            check("rr_gnt", bus.gnt, exp_g);
            wait_done(c);
            if (k > 0) check("done_spacing", cyc_cnt - prev, 11);
            prev = cyc_cnt;
            if (k == 4) bus.req = '0;
        end
        @(negedge clk);

        // 5: abort during RUN bit 3, then priority falls to requester 0
        bus.req_data[1*8 +: 8] = 8'h5B;
        bus.req = 4'b0010;
        wait_gnt(c);
        check("gnt1", bus.gnt, 4'b0010);
        repeat (4) @(negedge clk);
        check("run_bit3_en", bus.eng_en, 1);
        bus.req = '0;
        @(negedge clk);
        check("abort_state", {bus.gnt, bus.busy, bus.eng_en, bus.done}, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_done", bus.done, 0);
        end
        push(0, 8'h11, 8'hEE);
        bus.req = 4'b0011;
        wait_gnt(c);
        check("post_abort_gnt", bus.gnt, 4'b0001);
        wait_done(c);
        bus.req = '0;
        @(negedge clk);

        // 6: async reset in RUN bit 5, then a clean transaction
        bus.req_data[2*8 +: 8] = 8'hC3;
        bus.req = 4'b0100;
        push(2, 8'hC3, 8'h3C);
        wait_gnt(c);
        check("gnt2", bus.gnt, 4'b0100);
        repeat (6) @(negedge clk);
        check("run_bit5_en", bus.eng_en, 1);
        res = 1'b0;
        #1;
        check("async_rst_ctl", {bus.gnt, bus.busy, bus.done, bus.eng_init, bus.eng_en, bus.eng_x}, 0);
        check("async_rst_res", {bus.res_t1, bus.res_t2, 2'(bus.done_id)}, 0);
        sb.delete();
        bus.req = '0;
        @(negedge clk);
        @(negedge clk);
        res = 1'b1;
        @(negedge clk);
        check("post_rst_idle", {bus.gnt, bus.busy}, 0);
        bus.req_data[2*8 +: 8] = 8'h96;
        push(2, 8'h96, 8'h69);
        bus.req = 4'b0100;
        wait_gnt(c);
        check("gnt2_again", bus.gnt, 4'b0100);
        wait_done(c);
        check("done_latency_rst", c, 9);
        bus.req = '0;
        @(negedge clk);
        check("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
